vend_timer_arbiter: RTL and testbench

- Shares one seconds-countdown timer among three vending-machine requesters: dispense motor, coin return, and idle/display timeout.
- Contains its own prescaler that turns the system clock into a one-cycle 1-second tick enable. No derived clocks.
- Grants the timer with round-robin priority, counts down the requested seconds, then pulses done to the owner.
- Sits between the vending control FSM units and the system clock domain.

---
 rtl/vend_timer_arbiter.sv | 147 ++++++++++++++
 tb/tb_vend_timer_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/vend_timer_arbiter.sv
// Round-robin arbiter sharing one seconds countdown among three vending requesters.
// Optional door-open pause input enabled by defining TIMER_PAUSE_EN.
module vend_timer_arbiter #(
  parameter int unsigned TICK_DIV = 40000000,
  parameter int unsigned SEC_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       req,
  input  logic [SEC_W-1:0] secs0,
  input  logic [SEC_W-1:0] secs1,
  input  logic [SEC_W-1:0] secs2,
`ifdef TIMER_PAUSE_EN
  input  logic             pause,
`endif
  output logic [2:0]       gnt,
  output logic [2:0]       done,
  output logic             busy,
  output logic             tick_1s,
  output logic [SEC_W-1:0] remaining
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_COUNT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [1:0]       owner_q, owner_d;
  logic [1:0]       last_q, last_d;
  logic [SEC_W-1:0] rem_q, rem_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             tick_q, tick_d;
  logic [1:0]       win;
  logic [SEC_W-1:0] win_secs;
  logic             stall;

`ifdef TIMER_PAUSE_EN
  assign stall = pause && (state_q == ST_COUNT);
`else
  assign stall = 1'b0;
`endif

  // tick is registered so that a full second of TICK_DIV cycles elapses after a grant
  assign tick_1s   = tick_q & ~stall;
  assign busy      = (state_q != ST_IDLE);
  assign gnt       = busy ? (3'b001 << owner_q) : 3'b000;
  assign done      = (state_q == ST_DONE) ? (3'b001 << owner_q) : 3'b000;
  assign remaining = rem_q;

  // Scan starts just after the last winner
  always_comb begin
    win = 2'd0;
    case (last_q)
      2'd0: begin
        if (req[1])      win = 2'd1;
        else if (req[2]) win = 2'd2;
        else             win = 2'd0;
      end
      2'd1: begin
        if (req[2])      win = 2'd2;
        else if (req[0]) win = 2'd0;
        else             win = 2'd1;
      end
      default: begin
        if (req[0])      win = 2'd0;
        else if (req[1]) win = 2'd1;
        else             win = 2'd2;
      end
    endcase
  end

  always_comb begin
    case (win)
      2'd0:    win_secs = secs0;
      2'd1:    win_secs = secs1;
      default: win_secs = secs2;
    endcase
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    rem_d   = rem_q;
    if (stall) begin
      presc_d = presc_q;
      tick_d  = tick_q;
    end else begin
      presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + PW'(1);
      tick_d  = (presc_q == PRESC_MAX);
    end

    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d = ST_GRANT;
          owner_d = win;
          rem_d   = win_secs;
          presc_d = '0;
          tick_d  = 1'b0;
        end
      end
      ST_GRANT: begin
        state_d = (rem_q == '0) ? ST_DONE : ST_COUNT;
      end
      ST_COUNT: begin
        if (!req[owner_q]) begin
          // Abort: no done pulse, but the pointer still moves past this requester
          state_d = ST_IDLE;
          rem_d   = '0;
          last_d  = owner_q;
        end else if (tick_1s && (rem_q != '0)) begin
          rem_d = rem_q - SEC_W'(1);
          if (rem_q == SEC_W'(1)) state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        rem_d   = '0;
        last_d  = owner_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= 2'd0;
      last_q  <= 2'd2;
      rem_q   <= '0;
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      rem_q   <= rem_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
    end
  end

endmodule

// File: tb/tb_vend_timer_arbiter.sv
// Directed bench for vend_timer_arbiter with a done-pulse scoreboard (TICK_DIV = 4).
module tb_vend_timer_arbiter;

  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned SEC_W    = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [2:0]       req;
  logic [SEC_W-1:0] secs0, secs1, secs2;
  logic             pause;
  logic [2:0]       gnt, done;
  logic             busy, tick_1s;
  logic [SEC_W-1:0] remaining;

  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;
  int unsigned g, g2, k;

  typedef struct {
    logic [2:0]  vec;
    int unsigned cyc;
  } exp_t;
  exp_t exp_q[$];
  exp_t e;

  logic [2:0] order [4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vend_timer_arbiter #(
    .TICK_DIV (TICK_DIV),
    .SEC_W    (SEC_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .secs0     (secs0),
    .secs1     (secs1),
    .secs2     (secs2),
`ifdef TIMER_PAUSE_EN
    .pause     (pause),
`endif
    .gnt       (gnt),
    .done      (done),
    .busy      (busy),
    .tick_1s   (tick_1s),
    .remaining (remaining)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic goto_cyc(input int unsigned target);
    while (cyc < target) @(negedge clk);
  endtask

  // Every done pulse must match the oldest expected entry, in vector and cycle
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done !== 3'b000) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", {29'd0, done}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("done_vec", {29'd0, done}, {29'd0, e.vec});
        check("done_cyc", cyc, e.cyc);
      end
    end
  end

  initial begin
    order[0] = 3'b001; order[1] = 3'b010; order[2] = 3'b100; order[3] = 3'b001;
    rst_n = 1'b0; req = 3'b000; pause = 1'b0;
    secs0 = '0; secs1 = '0; secs2 = '0;

    #3;
    check("rst_gnt", {29'd0, gnt}, 32'd0);
    check("rst_done", {29'd0, done}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_tick", {31'd0, tick_1s}, 32'd0);
    check("rst_rem", {24'd0, remaining}, 32'd0);
    step(2);
    rst_n = 1'b1;
    step(1);

    // Single 3-second ownership
    secs0 = 8'd3; req = 3'b001; g = cyc + 1;
    exp_q.push_back('{vec: 3'b001, cyc: g + 13});
    step(1);
    check("t1_gnt", {29'd0, gnt}, 32'h1);
    check("t1_busy", {31'd0, busy}, 32'd1);
    check("t1_rem3", {24'd0, remaining}, 32'd3);
    goto_cyc(g + 3);
    check("t1_notick", {31'd0, tick_1s}, 32'd0);
    goto_cyc(g + 4);
    check("t1_tick", {31'd0, tick_1s}, 32'd1);
    goto_cyc(g + 5);
    check("t1_rem2", {24'd0, remaining}, 32'd2);
    goto_cyc(g + 9);
    check("t1_rem1", {24'd0, remaining}, 32'd1);
    goto_cyc(g + 13);
    check("t1_gnt_done", {29'd0, gnt}, 32'h1);
    req = 3'b000;
    step(1);
    check("t1_idle_busy", {31'd0, busy}, 32'd0);
    check("t1_idle_gnt", {29'd0, gnt}, 32'd0);

    // Round robin with all three requesting
    rst_n = 1'b0; step(1); rst_n = 1'b1; step(1);
    secs0 = 8'd1; secs1 = 8'd1; secs2 = 8'd1; req = 3'b111; g = cyc + 1;
    for (int i = 0; i < 4; i++) exp_q.push_back('{vec: order[i], cyc: g + 7 * i + 5});
    for (int i = 0; i < 4; i++) begin
      goto_cyc(g + 7 * i);
      check("t2_gnt", {29'd0, gnt}, {29'd0, order[i]});
      if (i < 3) begin
        goto_cyc(g + 7 * i + 6);
        check("t2_gap_gnt", {29'd0, gnt}, 32'd0);
        check("t2_gap_busy", {31'd0, busy}, 32'd0);
      end
    end
    goto_cyc(g + 26);
    req = 3'b000;
    step(1);
    check("t2_end_busy", {31'd0, busy}, 32'd0);

    // Zero-second request
    secs1 = 8'd0; req = 3'b010; g = cyc + 1;
    exp_q.push_back('{vec: 3'b010, cyc: g + 1});
    step(1);
    check("t3_gnt_a", {29'd0, gnt}, 32'h2);
    check("t3_rem_a", {24'd0, remaining}, 32'd0);
    step(1);
    check("t3_gnt_b", {29'd0, gnt}, 32'h2);
    check("t3_rem_b", {24'd0, remaining}, 32'd0);
    req = 3'b000;
    step(1);
    check("t3_busy", {31'd0, busy}, 32'd0);

    // Abort by dropping the request, then pointer has moved past index 2
    secs2 = 8'd5; req = 3'b100; g = cyc + 1;
    step(1);
    check("t4_gnt", {29'd0, gnt}, 32'h4);
    goto_cyc(g + 6);
    check("t4_rem", {24'd0, remaining}, 32'd4);
    req = 3'b000;
    step(1);
    check("t4_abort_gnt", {29'd0, gnt}, 32'd0);
    check("t4_abort_rem", {24'd0, remaining}, 32'd0);
    check("t4_abort_busy", {31'd0, busy}, 32'd0);
    secs0 = 8'd1; req = 3'b101; g2 = cyc + 1;
    exp_q.push_back('{vec: 3'b001, cyc: g2 + 5});
    step(1);
    check("t4_regrant", {29'd0, gnt}, 32'h1);
    goto_cyc(g2 + 5);
    req = 3'b000;
    step(1);

    // Asynchronous reset mid-count
    secs0 = 8'd10; req = 3'b001;
    step(6);
    check("t5_busy_pre", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_gnt", {29'd0, gnt}, 32'd0);
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_rem", {24'd0, remaining}, 32'd0);
    check("t5_tick", {31'd0, tick_1s}, 32'd0);
    check("t5_done", {29'd0, done}, 32'd0);
    req = 3'b000;
    step(2);
    rst_n = 1'b1;
    k = cyc;
    for (int i = 1; i <= 3; i++) begin
      goto_cyc(k + i);
      check("t5_tick_low", {31'd0, tick_1s}, 32'd0);
    end
    goto_cyc(k + 4);
    check("t5_tick_first", {31'd0, tick_1s}, 32'd1);
    step(1);

`ifdef TIMER_PAUSE_EN
    // Pause freezes the countdown for exactly its duration
    secs0 = 8'd2; req = 3'b001; g = cyc + 1;
    exp_q.push_back('{vec: 3'b001, cyc: g + 29});
    step(1);
    check("t6_gnt", {29'd0, gnt}, 32'h1);
    goto_cyc(g + 1);
    pause = 1'b1;
    for (int i = 2; i <= 20; i++) begin
      goto_cyc(g + i);
      check("t6_tick_frozen", {31'd0, tick_1s}, 32'd0);
      check("t6_rem_frozen", {24'd0, remaining}, 32'd2);
    end
    goto_cyc(g + 21);
    pause = 1'b0;
    goto_cyc(g + 29);
    req = 3'b000;
    step(1);
`endif

    step(3);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
